// File: rtl/vidin_pkg.sv
// Shared types and defaults for the video-input filter sequencing blocks.
package vidin_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int HORIZ_LENGTH_DEF = 226;
  localparam int FRAME_LINES_DEF  = 480;
  localparam int TAPS_DEF         = 7;
  localparam int FLTR_LAT_DEF     = 3;

  // Bits needed to hold values 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vidin_valid_pipe.sv
// One-bit delay line that tracks pixel validity alongside a filter pipeline.
module vidin_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic dout_o
);

  logic [DEPTH-1:0] sr_q;

  // Shift every cycle; validity never stalls, it follows the data clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/vidin_fltr_ctrl.sv
// Sequencer for the line-buffer chain and vertical filter bank.
//   state | meaning
//   IDLE  | waiting for frame_start; stray pixel strobes are dropped
//   PRIME | fewer than TAPS-1 lines buffered, filter window incomplete
//   RUN   | window holds TAPS real lines, filter output is meaningful
module vidin_fltr_ctrl
  import vidin_pkg::*;
#(
  parameter int HORIZ_LENGTH = HORIZ_LENGTH_DEF,
  parameter int FRAME_LINES  = FRAME_LINES_DEF,
  parameter int TAPS         = TAPS_DEF,
  parameter int FLTR_LAT     = FLTR_LAT_DEF,
  parameter int COL_W        = cnt_width(HORIZ_LENGTH),
  parameter int ROW_W        = cnt_width(FRAME_LINES)
) (
  input  logic             tm3_clk_v0,
  input  logic             rst,
  input  logic             vidin_new_data,
  input  logic             vidin_frame_start,
  output logic             buff_wen,
  output logic [COL_W-1:0] col_cnt,
  output logic [ROW_W-1:0] row_cnt,
  output logic             window_valid,
  output logic             fltr_out_valid,
  output logic             line_done,
  output logic             frame_done,
  output logic             err_sync
);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(HORIZ_LENGTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(FRAME_LINES - 1);
  localparam logic [ROW_W-1:0] ROW_PRIME = ROW_W'(TAPS - 1);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic             err_q, err_d;

  state_e           base_state;
  logic [COL_W-1:0] base_col;
  logic [ROW_W-1:0] base_row;
  logic             accept;

  assign accept       = vidin_new_data & ((state_q != IDLE) | vidin_frame_start);
  assign buff_wen     = accept;
  // A restart pixel starts a new frame, so it never has a full window.
  assign window_valid = accept & (state_q == RUN) & ~vidin_frame_start;

  // Register state, position and the one-cycle status pulses.
  always_ff @(posedge tm3_clk_v0 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  // Frame sync first rebases position to (0,0); an accepted pixel then advances from there.
  always_comb begin
    base_state = state_q;
    base_col   = col_q;
    base_row   = row_q;
    err_d      = 1'b0;
    line_d     = 1'b0;
    frame_d    = 1'b0;

    if (vidin_frame_start) begin
      base_state = PRIME;
      base_col   = '0;
      base_row   = '0;
      err_d      = (col_q != '0) | (row_q != '0);
    end

    state_d = base_state;
    col_d   = base_col;
    row_d   = base_row;

    if (accept) begin
      if (base_col == COL_LAST) begin
        col_d  = '0;
        line_d = 1'b1;
        if (base_row == ROW_LAST) begin
          row_d   = '0;
          frame_d = 1'b1;
          state_d = IDLE;
        end else begin
          row_d   = base_row + 1'b1;
          state_d = (row_d >= ROW_PRIME) ? RUN : PRIME;
        end
      end else begin
        col_d = base_col + 1'b1;
      end
    end
  end

  // One stage for the fifo write plus one per filter register.
  vidin_valid_pipe #(
    .DEPTH(FLTR_LAT + 1)
  ) u_valid_pipe (
    .clk_i (tm3_clk_v0),
    .rst_i (rst),
    .din_i (window_valid),
    .dout_o(fltr_out_valid)
  );

  assign col_cnt    = col_q;
  assign row_cnt    = row_q;
  assign line_done  = line_q;
  assign frame_done = frame_q;
  assign err_sync   = err_q;

endmodule

// File: tb/tb_vidin_fltr_ctrl.sv
// Directed bench for vidin_fltr_ctrl with a 4x5 frame and a 3-tap window.
module tb_vidin_fltr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       nd = 1'b0;
  logic       fs = 1'b0;
  logic       buff_wen, window_valid, fltr_out_valid, line_done, frame_done, err_sync;
  logic [1:0] col_cnt;
  logic [2:0] row_cnt;

  int passed = 0;
  int total  = 0;

  vidin_fltr_ctrl #(
    .HORIZ_LENGTH(4), .FRAME_LINES(5), .TAPS(3), .FLTR_LAT(3), .COL_W(2), .ROW_W(3)
  ) dut (
    .tm3_clk_v0       (clk),
    .rst              (rst),
    .vidin_new_data   (nd),
    .vidin_frame_start(fs),
    .buff_wen         (buff_wen),
    .col_cnt          (col_cnt),
    .row_cnt          (row_cnt),
    .window_valid     (window_valid),
    .fltr_out_valid   (fltr_out_valid),
    .line_done        (line_done),
    .frame_done       (frame_done),
    .err_sync         (err_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
  endtask

  // Drive inputs mid-cycle, then let combinational outputs settle.
  task automatic step(input logic n, input logic f);
    @(negedge clk);
    nd = n;
    fs = f;
    #1;
  endtask

  initial begin
    int n;
    // Reset values while reset is held
    #2;
    chk("rst_buff_wen", 0, buff_wen, 0);
    chk("rst_fltr", 0, fltr_out_valid, 0);
    chk("rst_line", 0, line_done, 0);
    chk("rst_col", 0, col_cnt, 0);
    chk("rst_row", 0, row_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Stray strobes in IDLE are dropped
    for (int c = 0; c < 3; c++) begin
      step(1, 0);
      chk("idle_buff_wen", c, buff_wen, 0);
      chk("idle_win", c, window_valid, 0);
      chk("idle_col", c, col_cnt, 0);
      chk("idle_row", c, row_cnt, 0);
    end

    // Contiguous frame of 20 pixels, then 5 idle cycles to drain
    for (int c = 0; c < 25; c++) begin
      step(c < 20, c == 0);
      chk("b2b_buff_wen", c, buff_wen, (c < 20));
      chk("b2b_win", c, window_valid, (c >= 8 && c < 20));
      chk("b2b_col", c, col_cnt, (c < 20) ? c % 4 : 0);
      chk("b2b_row", c, row_cnt, (c < 20) ? c / 4 : 0);
      chk("b2b_line", c, line_done, (c == 4 || c == 8 || c == 12 || c == 16 || c == 20));
      chk("b2b_frame", c, frame_done, (c == 20));
      chk("b2b_fltr", c, fltr_out_valid, (c >= 12 && c <= 23));
      chk("b2b_err", c, err_sync, 0);
    end

    // Strobes every third cycle across a full frame
    for (int c = 0; c < 64; c++) begin
      step((c % 3 == 0) && (c < 60), c == 0);
      n = (c + 2) / 3;
      if (n >= 20) n = 0;
      chk("sp_buff_wen", c, buff_wen, (c % 3 == 0) && (c < 60));
      chk("sp_col", c, col_cnt, n % 4);
      chk("sp_row", c, row_cnt, n / 4);
      chk("sp_frame", c, frame_done, (c == 58));
      chk("sp_fltr", c, fltr_out_valid, (c >= 28 && c <= 61 && (c - 4) % 3 == 0));
    end

    // Mid-frame resync at pixel (1,2)
    for (int c = 0; c < 9; c++) begin
      step(1, c == 0);
      chk("rs_err_pre", c, err_sync, 0);
    end
    step(1, 1);
    chk("rs_col_pre", 9, col_cnt, 1);
    chk("rs_row_pre", 9, row_cnt, 2);
    chk("rs_buff_wen", 9, buff_wen, 1);
    chk("rs_win", 9, window_valid, 0);
    for (int c = 10; c < 20; c++) begin
      step(1, 0);
      chk("rs_err", c, err_sync, (c == 10));
      chk("rs_win", c, window_valid, (c >= 17));
      if (c == 10) begin
        chk("rs_col_post", c, col_cnt, 1);
        chk("rs_row_post", c, row_cnt, 0);
      end
      if (c == 12) chk("rs_drain", c, fltr_out_valid, 1);
      if (c == 13) chk("rs_drain_end", c, fltr_out_valid, 0);
    end

    // Asynchronous reset mid-RUN with valids in flight
    #2;
    rst = 1'b1;
    #1;
    chk("ar_fltr", 0, fltr_out_valid, 0);
    chk("ar_line", 0, line_done, 0);
    chk("ar_frame", 0, frame_done, 0);
    chk("ar_err", 0, err_sync, 0);
    chk("ar_col", 0, col_cnt, 0);
    chk("ar_row", 0, row_cnt, 0);
    chk("ar_buff_wen", 0, buff_wen, 0);
    chk("ar_win", 0, window_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step(1, 0);
      chk("post_rst_fltr", c, fltr_out_valid, 0);
      chk("post_rst_buff_wen", c, buff_wen, 0);
      chk("post_rst_col", c, col_cnt, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vidin_fltr_ctrl.md
Name: vidin_fltr_ctrl

Overview:
Sequencing controller for the video-input line-buffer chain and the 7-tap vertical filter bank. It qualifies the raw pixel strobe into a shift enable for the fifo226 chain, and tracks column and row position within the frame. It decides when the vertical window holds TAPS real lines and aligns a valid strobe with the filter output pipeline. It also reports line and frame boundaries and sync errors to downstream consumers.

Parameters:
HORIZ_LENGTH, 226, pixels per line (fifo226 line length)
FRAME_LINES, 480, lines per frame
TAPS, 7, vertical filter taps; window valid once TAPS-1 lines are buffered
FLTR_LAT, 3, filter register stages (q, d_out_tmp, dout)
COL_W, 8, column counter width, ceil(log2(HORIZ_LENGTH))
ROW_W, 9, row counter width, ceil(log2(FRAME_LINES))

Ports:
tm3_clk_v0  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
vidin_new_data  in  1  one-cycle pixel strobe from video input
vidin_frame_start  in  1  frame sync; qualifies the pixel strobed in the same cycle as pixel (0,0)
buff_wen  out  1  shift enable to every fifo226 wen; combinational
col_cnt  out  COL_W  column of the next pixel to be accepted
row_cnt  out  ROW_W  row of the next pixel to be accepted
window_valid  out  1  accepted pixel has a full TAPS-line window; combinational, same cycle as buff_wen
fltr_out_valid  out  1  filter dout for a windowed pixel is valid this cycle
line_done  out  1  one-cycle pulse after the last pixel of a line is accepted
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted
err_sync  out  1  one-cycle pulse: frame_start arrived while col_cnt!=0 or row_cnt!=0

Behaviour:
- Reset (async): state=IDLE; col_cnt=0; row_cnt=0; valid pipeline cleared. Registered outputs fltr_out_valid, line_done, frame_done and err_sync are 0; buff_wen and window_valid evaluate to 0 from state.
- States:
  - IDLE: wait for a frame.
  - PRIME: row_cnt < TAPS-1.
  - RUN: row_cnt >= TAPS-1.
- accept = vidin_new_data & (state!=IDLE | vidin_frame_start).
- buff_wen = accept.
- window_valid = accept & (state==RUN), with restart qualification: it is 0 whenever frame_start is high.
- IDLE -> PRIME on vidin_frame_start. The strobe in that cycle, if present, is accepted as pixel (0,0). vidin_new_data without frame_start in IDLE is dropped: buff_wen=0 and no counter change.
- Each accept: col_cnt+1. When col_cnt==HORIZ_LENGTH-1:
  - col_cnt wraps to 0 and row_cnt increments.
  - line_done is 1 on the next cycle.
  - PRIME -> RUN when the new row_cnt == TAPS-1.
- Last pixel (col=HORIZ_LENGTH-1, row=FRAME_LINES-1) accepted:
  - col_cnt=0, row_cnt=0, state -> IDLE.
  - line_done and frame_done both pulse on the next cycle.
- vidin_frame_start while PRIME or RUN:
  - Counters restart at (0,0); the same-cycle strobe is accepted as pixel (0,0).
  - state -> PRIME.
  - err_sync pulses next cycle if the pre-restart position was not (0,0).
  - The valid pipeline is not flushed; in-flight valids drain normally.
- No pixel strobe: counters hold. Gaps between strobes are unlimited.
- Valid pipeline: FLTR_LAT+1 stage shift register, clocked every cycle, input window_valid. fltr_out_valid = last stage, so it is high exactly FLTR_LAT+1 cycles after the accept cycle (1 cycle fifo update, FLTR_LAT filter stages).
- Back-to-back strobes are supported at one per clock with no bubbles.
- Counters never exceed HORIZ_LENGTH-1 / FRAME_LINES-1.

Decomposition:
- Shared package vidin_pkg holds:
  - state enum (IDLE, PRIME, RUN)
  - HORIZ_LENGTH, TAPS and FLTR_LAT defaults
  - counter width functions
- One sub-module, vidin_valid_pipe: parameterised-depth 1-bit shift register with async reset. It is reusable by the other fltr_compute_* instances.

Test Plan:
Params HORIZ_LENGTH=4, FRAME_LINES=5, TAPS=3, FLTR_LAT=3 for all scenarios below.
1. Reset, then strobes with no frame_start -> buff_wen=0, col_cnt=row_cnt=0, state IDLE.
2. frame_start+strobe, then 19 contiguous strobes ->
   - buff_wen high for 20 cycles
   - line_done pulses after pixels 3, 7, 11, 15, 19
   - frame_done after pixel 19
   - return to IDLE with counters at 0
3. Same frame ->
   - window_valid low for pixels 0-7, high for pixels 8-19
   - fltr_out_valid high exactly 4 cycles after each of pixels 8-19 (12 pulses)
4. Strobes every 3rd cycle -> counters advance only on strobes; fltr_out_valid spacing is 3 cycles; each pulse is 4 cycles after its accept.
5. frame_start at pixel (1,2) -> err_sync pulse, counters restart at (0,0) (col_cnt=1 on the following cycle), window_valid low for the next 8 pixels.
6. Assert rst mid-RUN with valid pipeline non-empty -> all outputs 0 immediately; no further fltr_out_valid until a new frame_start.
